// File: rtl/adsr_core.sv
// MMIO slot core generating a 16-bit ADSR amplitude envelope from a 32-bit accumulator.
// Configuration registers are written over the slot bus; start/abort are write-only strobes.
module adsr_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    output logic [31:0] rd_data,
    input  logic [31:0] wr_data,
    output logic [15:0] env,
    output logic        adsr_idle
);

    typedef enum logic [2:0] {
        StIdle,
        StAttack,
        StDecay,
        StSustain,
        StRelease
    } state_e;

    localparam logic [31:0] AmpMax = 32'hFFFF_FFFF;

    state_e      state_q;
    logic [31:0] amp_q;
    logic [31:0] cnt_q;
    logic [31:0] attack_step_q;
    logic [31:0] decay_step_q;
    logic [31:0] sustain_level_q;
    logic [31:0] sustain_time_q;
    logic [31:0] release_step_q;

    logic        wr_en;
    logic        ctrl_wr;
    logic        start;
    logic        abort;
    logic [32:0] attack_sum;
    logic [32:0] decay_diff;
    logic [32:0] cnt_inc;
    logic        attack_done;
    logic        decay_done;
    logic        sustain_done;
    logic        release_done;

    // The read strobe has no side effects and only addr[2:0] is decoded.
    logic unused_inputs;
    assign unused_inputs = ^{read, addr[4:3]};

    assign wr_en   = cs & write;
    assign ctrl_wr = wr_en && (addr[2:0] == 3'd5);
    assign start   = ctrl_wr & wr_data[0];
    assign abort   = ctrl_wr & wr_data[1];

    // 33-bit arithmetic so no step can wrap the accumulator.
    always_comb begin
        attack_sum   = {1'b0, amp_q} + {1'b0, attack_step_q};
        decay_diff   = {1'b0, amp_q} - {1'b0, decay_step_q};
        cnt_inc      = {1'b0, cnt_q} + 33'd1;
        attack_done  = (attack_step_q == 32'd0) || (attack_sum >= {1'b0, AmpMax});
        // Signed compare: an underflowed difference counts as reaching sustain.
        decay_done   = (decay_step_q == 32'd0) ||
                       ($signed(decay_diff) <= $signed({1'b0, sustain_level_q}));
        sustain_done = cnt_inc >= {1'b0, sustain_time_q};
        release_done = (release_step_q == 32'd0) || (amp_q <= release_step_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            amp_q           <= 32'd0;
            cnt_q           <= 32'd0;
            attack_step_q   <= 32'd0;
            decay_step_q    <= 32'd0;
            sustain_level_q <= 32'd0;
            sustain_time_q  <= 32'd0;
            release_step_q  <= 32'd0;
        end else begin
            if (wr_en) begin
                case (addr[2:0])
                    3'd0:    attack_step_q   <= wr_data;
                    3'd1:    decay_step_q    <= wr_data;
                    3'd2:    sustain_level_q <= wr_data;
                    3'd3:    sustain_time_q  <= wr_data;
                    3'd4:    release_step_q  <= wr_data;
                    default: ;
                endcase
            end

            if (abort) begin
                state_q <= StIdle;
                amp_q   <= 32'd0;
            end else if (start) begin
                // Retrigger keeps the current amplitude so attack resumes without a click.
                state_q <= StAttack;
            end else begin
                case (state_q)
                    StIdle: begin
                        amp_q <= 32'd0;
                    end
                    StAttack: begin
                        if (attack_done) begin
                            amp_q   <= AmpMax;
                            state_q <= StDecay;
                        end else begin
                            amp_q <= attack_sum[31:0];
                        end
                    end
                    StDecay: begin
                        if (decay_done) begin
                            amp_q   <= sustain_level_q;
                            cnt_q   <= 32'd0;
                            state_q <= StSustain;
                        end else begin
                            amp_q <= decay_diff[31:0];
                        end
                    end
                    StSustain: begin
                        if (sustain_done) begin
                            state_q <= StRelease;
                        end else begin
                            cnt_q <= cnt_inc[31:0];
                        end
                    end
                    StRelease: begin
                        if (release_done) begin
                            amp_q   <= 32'd0;
                            state_q <= StIdle;
                        end else begin
                            amp_q <= amp_q - release_step_q;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        amp_q   <= 32'd0;
                    end
                endcase
            end
        end
    end

    assign env       = amp_q[31:16];
    assign adsr_idle = (state_q == StIdle);

    always_comb begin
        rd_data = 32'd0;
        case (addr[2:0])
            3'd0:    rd_data = {31'd0, adsr_idle};
            3'd1:    rd_data = {16'd0, env};
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_adsr_core.sv
// Directed self-checking bench for adsr_core: envelope shapes, strobes, retrigger and gating.
module tb_adsr_core;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] rd_data;
    logic [31:0] wr_data;
    logic [15:0] env;
    logic        adsr_idle;

    int errors;
    int checks;

    localparam logic [15:0] FULL_ENV [21] = '{
        16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF,
        16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hBFFF, 16'hAFFF, 16'h9FFF, 16'h8FFF,
        16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
        16'h6000, 16'h4000, 16'h2000, 16'h0000
    };

    localparam logic [15:0] ZERO_ENV [5] = '{
        16'h0000, 16'hFFFF, 16'h1234, 16'h1234, 16'h0000
    };

    adsr_core dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .rd_data   (rd_data),
        .wr_data   (wr_data),
        .env       (env),
        .adsr_idle (adsr_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a write at the next rising edge; returns just after that edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic sel);
        @(negedge clk);
        cs      = sel;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        cs    = 1'b0;
        write = 1'b0;
        addr  = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_env(input string name, input logic [15:0] exp_env, input logic exp_idle);
        checks++;
        if (env !== exp_env || adsr_idle !== exp_idle) begin
            errors++;
            $display("FAIL %s: env=%h idle=%b, required env=%h idle=%b",
                     name, env, adsr_idle, exp_env, exp_idle);
        end
    endtask

    task automatic program_full();
        wr(5'd0, 32'h4000_0000, 1'b1);
        wr(5'd1, 32'h1000_0000, 1'b1);
        wr(5'd2, 32'h8000_0000, 1'b1);
        wr(5'd3, 32'd4, 1'b1);
        wr(5'd4, 32'h2000_0000, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_env("reset_out", 16'h0000, 1'b1);
        addr = 5'd0;
        #1;
        checks++;
        if (rd_data !== 32'd1) begin
            errors++;
            $display("FAIL reset_rd0: rd_data=%h required=%h", rd_data, 32'd1);
        end
        addr = 5'd1;
        #1;
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd1: rd_data=%h required=%h", rd_data, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_envelope();
        program_full();
        wr(5'd5, 32'd1, 1'b1);
        for (int i = 0; i < 21; i++) begin
            if (i > 0) step();
            check_env($sformatf("full_env[%0d]", i), FULL_ENV[i], (i == 20));
        end
        addr = 5'd1;
        #1;
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL full_rd1_end: rd_data=%h required=%h", rd_data, 32'd0);
        end
    endtask

    task automatic test_zero_steps();
        wr(5'd0, 32'd0, 1'b1);
        wr(5'd1, 32'd0, 1'b1);
        wr(5'd2, 32'h1234_0000, 1'b1);
        wr(5'd3, 32'd0, 1'b1);
        wr(5'd4, 32'd0, 1'b1);
        wr(5'd5, 32'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check_env($sformatf("zero_env[%0d]", i), ZERO_ENV[i], (i == 4));
        end
    endtask

    task automatic test_retrigger();
        program_full();
        wr(5'd5, 32'd1, 1'b1);
        // Index 18 of the full envelope is RELEASE at 0x4000.
        repeat (18) step();
        check_env("retrig_pre", 16'h4000, 1'b0);
        wr(5'd5, 32'd1, 1'b1);
        check_env("retrig_hold", 16'h4000, 1'b0);
        step();
        check_env("retrig_next", 16'h8000, 1'b0);
        step();
        check_env("retrig_next2", 16'hC000, 1'b0);
        wr(5'd5, 32'd2, 1'b1);
        check_env("retrig_abort", 16'h0000, 1'b1);
    endtask

    task automatic test_abort();
        wr(5'd5, 32'd1, 1'b1);
        check_env("abort_start", 16'h0000, 1'b0);
        step();
        step();
        check_env("abort_pre", 16'h8000, 1'b0);
        wr(5'd5, 32'd2, 1'b1);
        check_env("abort_edge", 16'h0000, 1'b1);
        wr(5'd5, 32'd3, 1'b1);
        check_env("abort_both", 16'h0000, 1'b1);
        step();
        check_env("abort_both_hold", 16'h0000, 1'b1);
    endtask

    task automatic test_gating();
        wr(5'd5, 32'd1, 1'b0);
        check_env("gate_cs0", 16'h0000, 1'b1);
        step();
        check_env("gate_cs0_hold", 16'h0000, 1'b1);
        wr(5'd6, 32'hFFFF_FFFF, 1'b1);
        wr(5'd7, 32'hFFFF_FFFF, 1'b1);
        step();
        check_env("gate_addr67", 16'h0000, 1'b1);
        addr = 5'd2;
        #1;
        checks++;
        if (rd_data !== 32'd0) begin
            errors++;
            $display("FAIL gate_rd2: rd_data=%h required=%h", rd_data, 32'd0);
        end
        // Upper address bits are not decoded: 13 aliases the control register.
        wr(5'd13, 32'd1, 1'b1);
        check_env("alias_start", 16'h0000, 1'b0);
        step();
        check_env("alias_step", 16'h4000, 1'b0);
        wr(5'd5, 32'd2, 1'b1);
        check_env("alias_abort", 16'h0000, 1'b1);
    endtask

    task automatic test_reset_mid();
        wr(5'd5, 32'd1, 1'b1);
        step();
        step();
        check_env("mid_pre", 16'h8000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_env("mid_reset", 16'h0000, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        // Config cleared: zero attack goes straight to max, then to sustain level 0.
        wr(5'd5, 32'd1, 1'b1);
        check_env("mid_cfg0", 16'h0000, 1'b0);
        step();
        check_env("mid_cfg1", 16'hFFFF, 1'b0);
        step();
        check_env("mid_cfg2", 16'h0000, 1'b0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = 5'd0;
        wr_data = 32'd0;
        test_reset();
        test_full_envelope();
        test_zero_steps();
        test_retrigger();
        test_abort();
        test_gating();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
